// File: rtl/multicore_normalizer_pkg.sv
// Shared types and helpers for the multi-core row normalizer.
package norm_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StSum,
        StDiv,
        StOut
    } state_t;

    // Index width; a single-entry dimension still needs one bit of index.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Accumulator width for the sum of |psum| over every entry of every core.
    function automatic int unsigned sum_w(input int unsigned bw, input int unsigned ncore,
                                          input int unsigned col);
        return bw + $clog2(ncore * col);
    endfunction

    // Magnitude of a sign-extended psum; callers keep the low BW_PSUM bits, which hold
    // |most-negative| exactly as an unsigned value.
    function automatic logic [31:0] signed_abs(input logic signed [31:0] v);
        return v[31] ? $unsigned(-v) : $unsigned(v);
    endfunction

endpackage

// File: rtl/multicore_normalizer_if.sv
// Row-input and element-output handshake bundle for the normalizer.
interface multicore_normalizer_if #(
    parameter int unsigned NCORE   = 4,
    parameter int unsigned COL     = 8,
    parameter int unsigned BW_PSUM = 11,
    parameter int unsigned W_OUT   = 11
);
    import norm_pkg::*;

    localparam int unsigned CORE_W = idx_w(NCORE);
    localparam int unsigned COL_W  = idx_w(COL);

    logic [NCORE-1:0]             s_valid;
    logic [NCORE-1:0]             s_ready;
    logic [NCORE*COL*BW_PSUM-1:0] psum;
    logic signed [W_OUT-1:0]      out_data;
    logic [CORE_W-1:0]            out_core;
    logic [COL_W-1:0]             out_col;
    logic                         out_valid;
    logic                         out_ready;
    logic                         busy;

    // Producer/consumer side (core array and downstream buffer).
    modport master (
        output s_valid, psum, out_ready,
        input  s_ready, out_data, out_core, out_col, out_valid, busy
    );

    // Normalizer side.
    modport slave (
        input  s_valid, psum, out_ready,
        output s_ready, out_data, out_core, out_col, out_valid, busy
    );

endinterface

// File: rtl/multicore_normalizer_seq_divider.sv
// Restoring divider producing FRAC+1 quotient bits, MSB first, one bit per cycle.
// Assumes quotient < 2^(FRAC+1), i.e. dividend >> (FRAC+1) < divisor.
module seq_divider #(
    parameter int unsigned SUM_W = 16,
    parameter int unsigned FRAC  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [SUM_W+FRAC-1:0] dividend,
    input  logic [SUM_W-1:0]      divisor,
    output logic [FRAC:0]         quotient,
    output logic                  done
);
    localparam int unsigned Q_W   = FRAC + 1;
    localparam int unsigned CNT_W = $clog2(Q_W + 1);

    logic [SUM_W-1:0] rem_q, rem_d;
    logic [FRAC:0]    low_q, low_d;
    logic [FRAC:0]    quot_q, quot_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             done_q, done_d;
    logic [SUM_W:0]   trial;

    // One shift-compare-subtract step per cycle; remainder stays below divisor.
    always_comb begin
        trial  = {rem_q, low_q[FRAC]};
        rem_d  = rem_q;
        low_d  = low_q;
        quot_d = quot_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start) begin
            // Upper dividend bits can only contribute zero quotient bits; preload them.
            rem_d  = SUM_W'(dividend >> Q_W);
            low_d  = dividend[FRAC:0];
            quot_d = '0;
            cnt_d  = CNT_W'(Q_W);
            run_d  = 1'b1;
        end else if (run_q) begin
            if (trial >= {1'b0, divisor}) begin
                rem_d  = SUM_W'(trial - {1'b0, divisor});
                quot_d = (quot_q << 1) | Q_W'(1);
            end else begin
                rem_d  = SUM_W'(trial);
                quot_d = quot_q << 1;
            end
            low_d = low_q << 1;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q  <= '0;
            low_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            low_q  <= low_d;
            quot_q <= quot_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign quotient = quot_q;
    assign done     = done_q;

endmodule

// File: rtl/multicore_normalizer.sv
// Collects one psum row per core, sums |psum| globally, then streams each entry out as
// the signed ratio psum*2^FRAC/sum, core-major and column-minor.
module multicore_normalizer
    import norm_pkg::*;
#(
    parameter int unsigned NCORE   = 4,
    parameter int unsigned COL     = 8,
    parameter int unsigned BW_PSUM = 11,
    parameter int unsigned FRAC    = 8,
    parameter int unsigned W_OUT   = 11
) (
    input logic                   clk,
    input logic                   reset,
    multicore_normalizer_if.slave bus
);
    localparam int unsigned SUM_W  = sum_w(BW_PSUM, NCORE, COL);
    localparam int unsigned CORE_W = idx_w(NCORE);
    localparam int unsigned COL_W  = idx_w(COL);

    if (W_OUT < FRAC + 2) begin : g_bad_w_out
        $error("multicore_normalizer: W_OUT must be >= FRAC+2");
    end

    state_t                     state_q, state_d;
    logic [NCORE-1:0]           got_q, got_d;
    logic signed [BW_PSUM-1:0]  rows_q [NCORE][COL];
    logic [CORE_W-1:0]          cidx_q, cidx_d;
    logic [SUM_W-1:0]           sum_q, sum_d;
    logic [CORE_W-1:0]          e_core_q, e_core_d;
    logic [COL_W-1:0]           e_col_q, e_col_d;
    logic                       div_run_q, div_run_d;
    logic signed [W_OUT-1:0]    out_data_q, out_data_d;
    logic [CORE_W-1:0]          out_core_q, out_core_d;
    logic [COL_W-1:0]           out_col_q, out_col_d;
    logic                       busy_q;

    logic [SUM_W-1:0]           row_abs_sum;
    logic signed [BW_PSUM-1:0]  cur_p;
    logic [BW_PSUM-1:0]         cur_mag;
    logic                       div_start;
    logic                       div_done;
    logic [FRAC:0]              div_quot;
    logic signed [W_OUT-1:0]    q_ext;
    logic signed [W_OUT-1:0]    div_result;
    logic                       last_elem;

    // Sum of |psum| for the core currently being accumulated.
    always_comb begin
        row_abs_sum = '0;
        for (int k = 0; k < COL; k++) begin
            row_abs_sum = row_abs_sum
                + SUM_W'(BW_PSUM'(signed_abs(32'(rows_q[cidx_q][k]))));
        end
    end

    // Current element operands and the signed result built from the divider magnitude.
    always_comb begin
        cur_p      = rows_q[e_core_q][e_col_q];
        cur_mag    = BW_PSUM'(signed_abs(32'(cur_p)));
        q_ext      = $signed(W_OUT'(div_quot));
        div_result = cur_p[BW_PSUM-1] ? -q_ext : q_ext;
        last_elem  = (e_core_q == CORE_W'(NCORE - 1)) && (e_col_q == COL_W'(COL - 1));
    end

    seq_divider #(
        .SUM_W (SUM_W),
        .FRAC  (FRAC)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend ((SUM_W + FRAC)'(cur_mag) << FRAC),
        .divisor  (sum_q),
        .quotient (div_quot),
        .done     (div_done)
    );

    // FSM next-state, bookkeeping and output-register loads.
    always_comb begin
        state_d    = state_q;
        got_d      = got_q;
        cidx_d     = cidx_q;
        sum_d      = sum_q;
        e_core_d   = e_core_q;
        e_col_d    = e_col_q;
        div_run_d  = div_run_q;
        div_start  = 1'b0;
        out_data_d = out_data_q;
        out_core_d = out_core_q;
        out_col_d  = out_col_q;
        unique case (state_q)
            StIdle: state_d = StCollect;
            StCollect: begin
                got_d = got_q | (bus.s_valid & ~got_q);
                // Registered got: the last row's handshake cycle never overlaps SUM.
                if (&got_q) begin
                    state_d = StSum;
                    cidx_d  = '0;
                    sum_d   = '0;
                end
            end
            StSum: begin
                sum_d = sum_q + row_abs_sum;
                if (cidx_q == CORE_W'(NCORE - 1)) begin
                    state_d   = StDiv;
                    e_core_d  = '0;
                    e_col_d   = '0;
                    div_run_d = 1'b0;
                end else begin
                    cidx_d = cidx_q + 1'b1;
                end
            end
            StDiv: begin
                if (!div_run_q) begin
                    if (sum_q == '0) begin
                        // All-zero row set: every ratio is zero, skip the divider.
                        out_data_d = '0;
                        out_core_d = e_core_q;
                        out_col_d  = e_col_q;
                        state_d    = StOut;
                    end else begin
                        div_start = 1'b1;
                        div_run_d = 1'b1;
                    end
                end else if (div_done) begin
                    out_data_d = div_result;
                    out_core_d = e_core_q;
                    out_col_d  = e_col_q;
                    div_run_d  = 1'b0;
                    state_d    = StOut;
                end
            end
            StOut: begin
                if (bus.out_ready) begin
                    if (last_elem) begin
                        got_d   = '0;
                        state_d = StCollect;
                    end else begin
                        state_d = StDiv;
                        if (e_col_q == COL_W'(COL - 1)) begin
                            e_col_d  = '0;
                            e_core_d = e_core_q + 1'b1;
                        end else begin
                            e_col_d = e_col_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            got_q      <= '0;
            cidx_q     <= '0;
            sum_q      <= '0;
            e_core_q   <= '0;
            e_col_q    <= '0;
            div_run_q  <= 1'b0;
            out_data_q <= '0;
            out_core_q <= '0;
            out_col_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            got_q      <= got_d;
            cidx_q     <= cidx_d;
            sum_q      <= sum_d;
            e_core_q   <= e_core_d;
            e_col_q    <= e_col_d;
            div_run_q  <= div_run_d;
            out_data_q <= out_data_d;
            out_core_q <= out_core_d;
            out_col_q  <= out_col_d;
            // Registered so busy reads 0 through reset and the IDLE cycle.
            busy_q     <= (state_d != StCollect);
        end
    end

    // Row buffers: latch each core's row on its handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NCORE; c++) begin
                for (int k = 0; k < COL; k++) begin
                    rows_q[c][k] <= '0;
                end
            end
        end else if (state_q == StCollect) begin
            for (int c = 0; c < NCORE; c++) begin
                if (bus.s_valid[c] && !got_q[c]) begin
                    for (int k = 0; k < COL; k++) begin
                        rows_q[c][k] <= bus.psum[(c*COL+k)*BW_PSUM +: BW_PSUM];
                    end
                end
            end
        end
    end

    assign bus.s_ready   = (state_q == StCollect) ? ~got_q : '0;
    assign bus.out_valid = (state_q == StOut);
    assign bus.out_data  = out_data_q;
    assign bus.out_core  = out_core_q;
    assign bus.out_col   = out_col_q;
    assign bus.busy      = busy_q;

endmodule
